// File: rtl/car_pkg.sv
// car_pkg: shared states, slot constants and frame helpers for the direction receiver
package car_pkg;
  typedef enum logic [1:0] {HUNT, DATA, LATCH} state_t;
  localparam int DEF_BIT_CYCLES = 50002;
  localparam int N_DATA_SLOTS = 8;
  localparam int LATCH_SLOT = 8;
  // Each direction bit is sent as a complementary pair (bit, ~bit).
  function automatic logic pairs_ok(input logic [7:0] f);
    return (f[1] ^ f[0]) & (f[3] ^ f[2]) & (f[5] ^ f[4]) & (f[7] ^ f[6]);
  endfunction
  function automatic logic [3:0] drt_of(input logic [7:0] f);
    return {f[6], f[4], f[2], f[0]};
  endfunction
  function automatic logic [7:0] err_sat(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for one asynchronous line
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic m;
  // Shift the raw line through two flops; q is safe to use in clk domain
  always_ff @(posedge clk or negedge rst)
    if (!rst) {q, m} <= 2'b00;
    else {q, m} <= {m, d};
endmodule

// File: rtl/dir_receiver.sv
// dir_receiver: decodes the 8-slot serial direction frame closed by a latch slot
module dir_receiver
  import car_pkg::*;
#(
  parameter int BIT_CYCLES = DEF_BIT_CYCLES,
  parameter int SAMPLE_POINT = BIT_CYCLES / 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dir_serial,
  input  logic        dir_enable,
  input  logic        dir_latch,
  output logic [3:0]  drt,
  output logic        drt_valid,
  output logic        frame_err,
  output logic [15:0] good_count,
  output logic [7:0]  err_count
);
  localparam int CW = $clog2(BIT_CYCLES);
  state_t state;
  logic s_serial, s_enable, s_latch, latch_d;
  logic [CW-1:0] cnt;
  logic [3:0] slot;
  logic [7:0] frame;
  logic at_sample, wrap;
  sync_2ff u_sync_serial (.clk(clk), .rst(rst), .d(dir_serial), .q(s_serial));
  sync_2ff u_sync_enable (.clk(clk), .rst(rst), .d(dir_enable), .q(s_enable));
  sync_2ff u_sync_latch  (.clk(clk), .rst(rst), .d(dir_latch),  .q(s_latch));
  assign at_sample = cnt == CW'(SAMPLE_POINT);
  assign wrap = cnt == CW'(BIT_CYCLES - 1);
  // Slot timing restarts from every latch falling edge, so drift never accumulates
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= HUNT;
      cnt <= '0;
      slot <= '0;
      frame <= '0;
      latch_d <= 1'b0;
      drt <= '0;
      drt_valid <= 1'b0;
      frame_err <= 1'b0;
      good_count <= '0;
      err_count <= '0;
    end else begin
      latch_d <= s_latch;
      drt_valid <= 1'b0;
      frame_err <= 1'b0;
      cnt <= (state == HUNT || wrap) ? '0 : cnt + 1'b1;
      slot <= (state == HUNT) ? '0 : slot + 4'(wrap);
      case (state)
        HUNT: if (latch_d && !s_latch) state <= DATA;
        DATA:
          if (at_sample && (!s_enable || s_latch)) begin
            frame_err <= 1'b1;
            err_count <= err_sat(err_count);
            state <= HUNT;
          end else begin
            if (at_sample) frame[slot[2:0]] <= s_serial;
            if (wrap && slot == 4'(N_DATA_SLOTS - 1)) state <= LATCH;
          end
        LATCH:
          if (at_sample && slot == 4'(LATCH_SLOT)) begin
            state <= HUNT;
            if (s_latch && !s_enable && pairs_ok(frame)) begin
              drt <= drt_of(frame);
              drt_valid <= 1'b1;
              good_count <= good_count + 16'd1;
            end else begin
              frame_err <= 1'b1;
              err_count <= err_sat(err_count);
            end
          end
        default: state <= HUNT;
      endcase
    end
endmodule
